// File: rtl/fp_accumulator_pkg.sv
// fp_accumulator_pkg: FP32 field constants, accumulator state encoding,
// adder request type and a leading-zero counter shared by the FP datapath.
package fp_accumulator_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_W   = 23;

    localparam logic [31:0] FP32_ZERO = 32'h00000000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } accState_t;

    typedef struct packed {
        logic [31:0] opA;
        logic [31:0] opB;
        logic        sub;
    } fpAddReq_t;

    // Leading zeros of a 27-bit aligned mantissa (27 when all zero)
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

endpackage

// File: rtl/fp_accumulator_addsub.sv
// fp_accumulator_addsub: combinational FP32 add/sub unit.
// Truncating (no rounding), no denormal support: the hidden bit is always
// assumed set, so an operand of +0.0 behaves like 2^-127 rather than zero.
// Exponent underflow flushes to signed zero, overflow saturates to Inf.
import fp_accumulator_pkg::*;

module fp_accumulator_addsub (
    input  fpAddReq_t   req,
    output logic [31:0] result
);

    logic        signB, swap, sgnBig, sgnSmall, effSub;
    logic [7:0]  expBig, expSmall, expDiff;
    logic [26:0] manBig, manSmall, manAligned;
    logic [27:0] rawSum;
    logic [4:0]  lz;
    logic [9:0]  expRes;
    logic [22:0] fracOut;

    // Swap to larger magnitude, align, add/sub, normalise, truncate
    always_comb begin
        signB = req.opB[SIGN_BIT] ^ req.sub;
        swap  = req.opB[EXP_MSB:0] > req.opA[EXP_MSB:0];
        if (swap) begin
            sgnBig   = signB;
            expBig   = req.opB[EXP_MSB:EXP_LSB];
            manBig   = {1'b1, req.opB[MANT_W-1:0], 3'b000};
            sgnSmall = req.opA[SIGN_BIT];
            expSmall = req.opA[EXP_MSB:EXP_LSB];
            manSmall = {1'b1, req.opA[MANT_W-1:0], 3'b000};
        end else begin
            sgnBig   = req.opA[SIGN_BIT];
            expBig   = req.opA[EXP_MSB:EXP_LSB];
            manBig   = {1'b1, req.opA[MANT_W-1:0], 3'b000};
            sgnSmall = signB;
            expSmall = req.opB[EXP_MSB:EXP_LSB];
            manSmall = {1'b1, req.opB[MANT_W-1:0], 3'b000};
        end
        expDiff    = expBig - expSmall;
        manAligned = (expDiff > 8'd26) ? '0 : (manSmall >> expDiff);
        effSub     = sgnBig ^ sgnSmall;
        rawSum     = effSub ? ({1'b0, manBig} - {1'b0, manAligned})
                            : ({1'b0, manBig} + {1'b0, manAligned});
        lz         = lzc27(rawSum[26:0]);

        if (rawSum[27]) begin
            expRes  = {2'b00, expBig} + 10'd1;
            fracOut = rawSum[26:4];
        end else begin
            expRes  = {2'b00, expBig} - {5'b00000, lz};
            fracOut = 23'((rawSum[26:0] << lz) >> 3);
        end

        if (rawSum == '0)
            result = FP32_ZERO;
        else if (expRes[9] || expRes == '0)
            result = {sgnBig, 31'h0};
        else if (expRes >= 10'd255)
            result = {sgnBig, 8'hFF, 23'h0};
        else
            result = {sgnBig, expRes[7:0], fracOut};
    end

endmodule

// File: rtl/fp_accumulator.sv
// fp_accumulator: sequential FP32 reduction over a valid/ready stream.
// The first element of a reduction is loaded directly (the adder cannot
// represent zero); later elements are summed through fp_accumulator_addsub.
// Optional macro FP_ACC_PIPE_EN: registers the adder output and inserts a
// WAIT cycle after every non-first accept.
import fp_accumulator_pkg::*;

module fp_accumulator #(
    parameter int CNT_W = 8
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_start,
    input  logic [CNT_W-1:0] in_count,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             out_ready,
    output logic             out_busy,
    output logic             out_done,
    output logic [31:0]      out_sum
);

    accState_t        state, nextState;
    logic [CNT_W-1:0] remaining;
    logic             first;
    logic             accept;
    logic             lastElem;
    logic [31:0]      addResult;
    fpAddReq_t        addReq;

    assign accept   = in_valid && out_ready;
    assign lastElem = (remaining == CNT_W'(1));
    assign addReq   = '{opA: out_sum, opB: in_data, sub: 1'b0};

    fp_accumulator_addsub uAdd (
        .req    (addReq),
        .result (addResult)
    );

    // State register
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) state <= ST_IDLE;
        else        state <= nextState;
    end

    // Next-state and handshake/status decode
    always_comb begin
        nextState = state;
        out_ready = 1'b0;
        out_busy  = (state != ST_IDLE);
        out_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_start) nextState = (in_count == '0) ? ST_DONE : ST_ACCUM;
            end
            ST_ACCUM: begin
                out_ready = 1'b1;
                if (in_valid) begin
`ifdef FP_ACC_PIPE_EN
                    if (!first)        nextState = ST_WAIT;
                    else if (lastElem) nextState = ST_DONE;
`else
                    if (lastElem) nextState = ST_DONE;
`endif
                end
            end
`ifdef FP_ACC_PIPE_EN
            ST_WAIT: begin
                nextState = (remaining == '0) ? ST_DONE : ST_ACCUM;
            end
`endif
            ST_DONE: begin
                out_done  = 1'b1;
                nextState = ST_IDLE;
            end
            default: nextState = ST_IDLE;
        endcase
    end

`ifdef FP_ACC_PIPE_EN
    logic [31:0] pipeSum;

    // Adder output register, written on every non-first accept
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst)               pipeSum <= FP32_ZERO;
        else if (accept && !first) pipeSum <= addResult;
    end
`endif

    // Accumulator, element counter and first-element flag
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            out_sum   <= FP32_ZERO;
            remaining <= '0;
            first     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_start) begin
                        out_sum   <= FP32_ZERO;
                        remaining <= in_count;
                        first     <= (in_count != '0);
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        remaining <= remaining - CNT_W'(1);
                        first     <= 1'b0;
                        if (first) out_sum <= in_data;
`ifndef FP_ACC_PIPE_EN
                        else       out_sum <= addResult;
`endif
                    end
                end
`ifdef FP_ACC_PIPE_EN
                ST_WAIT: out_sum <= pipeSum;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_accumulator.sv
// tb_fp_accumulator: scoreboard bench. Operands are multiples of 0.25 so every
// partial sum is exactly representable; the reference keeps the running sum as
// an integer count of quarters and encodes it to FP32 at the end.
module tb_fp_accumulator;

    localparam int CNT_W = 8;
`ifdef FP_ACC_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] count = '0;
    logic             valid = 1'b0;
    logic [31:0]      data = '0;
    logic             ready, busy, done;
    logic [31:0]      sum;

    int          errors = 0;
    int          checks = 0;
    int          opQ[$];
    logic [31:0] expQ[$];

    fp_accumulator #(.CNT_W(CNT_W)) dut (
        .in_clk    (clk),
        .in_rst    (rst),
        .in_start  (start),
        .in_count  (count),
        .in_valid  (valid),
        .in_data   (data),
        .out_ready (ready),
        .out_busy  (busy),
        .out_done  (done),
        .out_sum   (sum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Encode a positive number of quarters (value q/4, q < 2^24) as FP32
    function automatic logic [31:0] toFp(input int q);
        int         p;
        logic [31:0] m;
        logic [7:0]  e;
        if (q <= 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 31; i++) if (q[i]) p = i;
        e = 8'(127 + p - 2);
        m = 32'(q) << (23 - p);
        return {1'b0, e, m[22:0]};
    endfunction

    // Monitor: every done pulse is checked against the scoreboard head
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: sum %h, want no done", sum);
                end else begin
                    e = expQ.pop_front();
                    chk("sum_at_done", sum, e);
                end
            end
        end
    end

    // One reduction over opQ[0..n-1]; gapLen idle cycles before element 2,
    // optional random gaps, optional in_start pulse during a gap
    task automatic reduce(input int n, input int gapLen, input bit rndGap, input bit poke,
                          input bit useLit, input logic [31:0] lit);
        int          idx, guard, gapCnt, readyCycles, lat, qsum;
        bit          accepted, pend, expReady, poked;
        logic [31:0] expSum;
        qsum = 0;
        for (int i = 0; i < n; i++) qsum += opQ[i];
        expSum = useLit ? lit : toFp(qsum);
        expQ.push_back(expSum);

        // valid alongside start must be ignored in IDLE
        start = 1'b1; count = CNT_W'(n); valid = 1'b1; data = 32'h40400000;
        @(posedge clk); #1;
        start = 1'b0; valid = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);

        idx = 0; guard = 0; gapCnt = gapLen; readyCycles = 0;
        pend = 1'b0; poked = 1'b0; expReady = 1'b0;
        while (idx < n && guard < 3000) begin
            guard++;
            if (idx == 1 && gapCnt > 0) begin valid = 1'b0; gapCnt--; end
            else if (rndGap && $urandom_range(0, 3) == 0) valid = 1'b0;
            else valid = 1'b1;
            data = valid ? toFp(opQ[idx]) : 32'hDEADBEEF;
            if (poke && !valid && !poked && idx > 0) begin
                start = 1'b1; count = CNT_W'(3); poked = 1'b1;
            end
            @(negedge clk);
            if (pend) begin
                chk("ready_after_accept", 32'(ready), 32'(expReady));
                pend = 1'b0;
            end
            if (ready) readyCycles++;
            accepted = valid && ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (accepted) begin
                idx++;
                if (idx < n) begin
                    pend = 1'b1;
                    expReady = PIPE ? (idx == 1) : 1'b1;
                end
            end
        end
        if (idx < n) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: accepted %0d, want %0d", idx, n);
        end
        valid = 1'b0; data = '0;
        if (gapLen == 0 && !rndGap && n > 0) chk("ready_cycles", 32'(readyCycles), 32'(n));

        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) chk("ready_low_after_last", 32'(ready), 32'd0);
            if (done) begin lat = c; break; end
        end
        chk("done_latency", 32'(lat), (PIPE && n > 1) ? 32'd2 : 32'd1);

        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_after_done", 32'(busy), 32'd0);
        chk("sum_held", sum, expSum);
    endtask

    initial begin
        rst = 1'b1;
        #12;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", sum, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1.0 + 2.0 + 0.5 = 3.5
        opQ = '{4, 8, 2};
        reduce(3, 0, 1'b0, 1'b0, 1'b1, 32'h40600000);
        // 4.0, 4-cycle gap, 4.0 = 8.0
        opQ = '{16, 16};
        reduce(2, 4, 1'b0, 1'b0, 1'b1, 32'h41000000);
        // empty reduction
        opQ.delete();
        reduce(0, 0, 1'b0, 1'b0, 1'b1, 32'h00000000);
        // single element passes straight through
        opQ = '{4};
        reduce(1, 0, 1'b0, 1'b0, 1'b1, 32'h3F800000);
        // in_start pulsed mid-reduction must be ignored
        opQ = '{12, 5, 40, 1, 7};
        reduce(5, 3, 1'b0, 1'b1, 1'b0, 32'h0);

        // asynchronous reset mid-reduction
        start = 1'b1; count = CNT_W'(5);
        @(posedge clk); #1;
        start = 1'b0; valid = 1'b1; data = toFp(12);
        repeat (3) @(posedge clk);
        #1;
        valid = 1'b0;
        chk("busy_before_rst", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(ready), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_sum", sum, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 2.0 * 3 = 6.0 after reset
        opQ = '{8, 8, 8};
        reduce(3, 0, 1'b0, 1'b0, 1'b1, 32'h40C00000);

        for (int r = 0; r < 20; r++) begin
            int n;
            n = int'($urandom_range(0, 12));
            opQ.delete();
            for (int i = 0; i < n; i++) opQ.push_back(int'($urandom_range(1, 1023)));
            reduce(n, 0, 1'b1, ($urandom_range(0, 1) == 1), 1'b0, 32'h0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // full-width count
        opQ.delete();
        for (int i = 0; i < 255; i++) opQ.push_back(int'($urandom_range(1, 1023)));
        reduce(255, 0, 1'b1, 1'b0, 1'b0, 32'h0);

        chk("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
